// File: rtl/execute_stage_pkg.sv
// Encodings shared by the decoder, hazard unit and execute stage.
// Also holds the forwarding mux helper so every stage decodes the selects the same way.
package execute_stage_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_SLTU = 3'b110,
    ALU_LUI  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10,
    FWD_RSVD = 2'b11
  } fwd_sel_e;

  // The reserved select falls back to the register-file value.
  function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                          input logic [31:0] rf,
                                          input logic [31:0] wb,
                                          input logic [31:0] mem);
    logic [31:0] r;
    case (sel)
      FWD_WB:  r = wb;
      FWD_MEM: r = mem;
      default: r = rf;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/execute_stage_alu.sv
// 32-bit combinational ALU; wrap-around arithmetic, no flags.
// Zero latency, no flow control.
module alu
  import execute_stage_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'b0, a < b};
      default:  y = b;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: forwarding muxes, ALU, branch resolution and the E/M pipeline register.
// Redirect outputs are combinational; *M outputs follow one cycle later with no stall.
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic        JumpE,
  input  logic        BeqE,
  input  logic        BneE,
  input  logic        BltE,
  input  logic        BgeE,
  input  logic        ALUSrcE,
  input  logic [1:0]  ResultSrcE,
  input  logic [2:0]  ALUControlE,
  input  logic [31:0] Rd1E,
  input  logic [31:0] Rd2E,
  input  logic [31:0] PCE,
  input  logic [31:0] ExtImmE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic [1:0]  ResultSrcM,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M,
  output logic [4:0]  RdM
);

  logic [31:0] src_a;
  logic [31:0] write_data_e;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic        zero;
  logic        lt;

  assign src_a        = fwd_mux(ForwardAE, Rd1E, ResultW, ALUResultM);
  assign write_data_e = fwd_mux(ForwardBE, Rd2E, ResultW, ALUResultM);
  assign src_b        = ALUSrcE ? ExtImmE : write_data_e;

  alu u_alu (
    .a  (src_a),
    .b  (src_b),
    .op (ALUControlE),
    .y  (alu_result)
  );

  // Branch compare always uses the forwarded register pair, never the immediate.
  assign zero = (src_a == write_data_e);
  assign lt   = $signed(src_a) < $signed(write_data_e);

  assign PCSrcE    = JumpE | (BeqE & zero) | (BneE & ~zero) | (BltE & lt) | (BgeE & ~lt);
  assign PCTargetE = PCE + ExtImmE;

  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 2'b00;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RdM        <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      ALUResultM <= alu_result;
      WriteDataM <= write_data_e;
      PCPlus4M   <= PCPlus4E;
      RdM        <= RdE;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed table-driven bench for execute_stage plus reset corner sequences.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, MemWriteE, JumpE, BeqE, BneE, BltE, BgeE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] Rd1E, Rd2E, PCE, ExtImmE, PCPlus4E;
  logic [4:0]  RdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BeqE(BeqE), .BneE(BneE), .BltE(BltE), .BgeE(BgeE), .ALUSrcE(ALUSrcE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .Rd1E(Rd1E), .Rd2E(Rd2E), .PCE(PCE), .ExtImmE(ExtImmE), .PCPlus4E(PCPlus4E),
    .RdE(RdE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
  );

  // br packs {jump, beq, bne, blt, bge}
  typedef struct {
    logic [2:0]  alu;
    logic        alusrc;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] resw;
    logic [4:0]  br;
    logic        regw;
    logic        memw;
    logic [1:0]  rsrc;
    logic [4:0]  rd;
    logic        e_pcsrc;
    logic [31:0] e_tgt;
    logic [31:0] e_alu;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ALUControlE = v.alu;
    ALUSrcE     = v.alusrc;
    ForwardAE   = v.fa;
    ForwardBE   = v.fb;
    Rd1E        = v.rd1;
    Rd2E        = v.rd2;
    ExtImmE     = v.imm;
    PCE         = v.pc;
    PCPlus4E    = v.pc + 32'd4;
    ResultW     = v.resw;
    {JumpE, BeqE, BneE, BltE, BgeE} = v.br;
    RegWriteE   = v.regw;
    MemWriteE   = v.memw;
    ResultSrcE  = v.rsrc;
    RdE         = v.rd;
  endtask

  task automatic chk_m_zero(input string tag);
    chk({tag, ".RegWriteM"},  32'(RegWriteM),  32'd0);
    chk({tag, ".MemWriteM"},  32'(MemWriteM),  32'd0);
    chk({tag, ".ResultSrcM"}, 32'(ResultSrcM), 32'd0);
    chk({tag, ".ALUResultM"}, ALUResultM,      32'd0);
    chk({tag, ".WriteDataM"}, WriteDataM,      32'd0);
    chk({tag, ".PCPlus4M"},   PCPlus4M,        32'd0);
    chk({tag, ".RdM"},        32'(RdM),        32'd0);
  endtask

  initial begin
    vecs.push_back('{3'b000, 1'b0, 2'b00, 2'b00, 32'd5, 32'd7, 32'd0, 32'h0, 32'h0, 5'b00000, 1'b1, 1'b0, 2'b00, 5'd3, 1'b0, 32'h0, 32'd12, 32'd7});
    vecs.push_back('{3'b000, 1'b1, 2'b10, 2'b00, 32'd0, 32'd0, 32'd4, 32'h10, 32'h0, 5'b00000, 1'b1, 1'b0, 2'b00, 5'd4, 1'b0, 32'h14, 32'd16, 32'd0});
    vecs.push_back('{3'b000, 1'b0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 32'h0, 5'b00010, 1'b0, 1'b0, 2'b00, 5'd0, 1'b1, 32'h120, 32'd0, 32'd1});
    vecs.push_back('{3'b000, 1'b0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 32'h0, 5'b00001, 1'b0, 1'b0, 2'b00, 5'd0, 1'b0, 32'h120, 32'd0, 32'd1});
    vecs.push_back('{3'b000, 1'b1, 2'b00, 2'b00, 32'd9, 32'd9, 32'd3, 32'h200, 32'h0, 5'b00100, 1'b0, 1'b0, 2'b00, 5'd0, 1'b0, 32'h203, 32'd12, 32'd9});
    vecs.push_back('{3'b000, 1'b1, 2'b00, 2'b00, 32'd9, 32'd9, 32'd3, 32'h200, 32'h0, 5'b01000, 1'b0, 1'b0, 2'b00, 5'd0, 1'b1, 32'h203, 32'd12, 32'd9});
    vecs.push_back('{3'b000, 1'b0, 2'b00, 2'b00, 32'h7FFFFFFF, 32'd1, 32'd0, 32'h300, 32'h0, 5'b00000, 1'b1, 1'b1, 2'b01, 5'd31, 1'b0, 32'h300, 32'h80000000, 32'd1});
    vecs.push_back('{3'b101, 1'b0, 2'b00, 2'b00, 32'h80000000, 32'd1, 32'd0, 32'h0, 32'h0, 5'b00000, 1'b1, 1'b0, 2'b00, 5'd1, 1'b0, 32'h0, 32'd1, 32'd1});
    vecs.push_back('{3'b110, 1'b0, 2'b00, 2'b00, 32'h80000000, 32'd1, 32'd0, 32'h0, 32'h0, 5'b00000, 1'b1, 1'b0, 2'b00, 5'd1, 1'b0, 32'h0, 32'd0, 32'd1});
    vecs.push_back('{3'b001, 1'b0, 2'b00, 2'b00, 32'd5, 32'd7, 32'd0, 32'h0, 32'h0, 5'b00000, 1'b1, 1'b0, 2'b10, 5'd2, 1'b0, 32'h0, 32'hFFFFFFFE, 32'd7});
    vecs.push_back('{3'b010, 1'b0, 2'b00, 2'b00, 32'hF0F000FF, 32'h0FF00F0F, 32'd0, 32'h0, 32'h0, 5'b00000, 1'b1, 1'b0, 2'b00, 5'd5, 1'b0, 32'h0, 32'h00F0000F, 32'h0FF00F0F});
    vecs.push_back('{3'b011, 1'b0, 2'b00, 2'b00, 32'hF0F000FF, 32'h0FF00F0F, 32'd0, 32'h0, 32'h0, 5'b00000, 1'b1, 1'b0, 2'b00, 5'd5, 1'b0, 32'h0, 32'hFFF00FFF, 32'h0FF00F0F});
    vecs.push_back('{3'b100, 1'b0, 2'b00, 2'b00, 32'hF0F000FF, 32'h0FF00F0F, 32'd0, 32'h0, 32'h0, 5'b00000, 1'b1, 1'b0, 2'b00, 5'd5, 1'b0, 32'h0, 32'hFF000FF0, 32'h0FF00F0F});
    vecs.push_back('{3'b111, 1'b1, 2'b00, 2'b00, 32'hAAAA, 32'h5555, 32'h12345000, 32'h0, 32'h0, 5'b00000, 1'b1, 1'b0, 2'b00, 5'd6, 1'b0, 32'h12345000, 32'h12345000, 32'h5555});
    vecs.push_back('{3'b000, 1'b0, 2'b01, 2'b01, 32'd1, 32'd2, 32'h40, 32'h500, 32'h100, 5'b01000, 1'b1, 1'b0, 2'b00, 5'd7, 1'b1, 32'h540, 32'h200, 32'h100});
    vecs.push_back('{3'b001, 1'b0, 2'b11, 2'b10, 32'd3, 32'd4, 32'd0, 32'h0, 32'h0, 5'b00010, 1'b1, 1'b0, 2'b00, 5'd8, 1'b1, 32'h0, 32'hFFFFFE03, 32'h200});
    vecs.push_back('{3'b000, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 32'h20, 32'hFFFFFFF0, 32'h0, 5'b10000, 1'b1, 1'b0, 2'b10, 5'd1, 1'b1, 32'h10, 32'd0, 32'd0});
    vecs.push_back('{3'b000, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'h600, 32'h0, 5'b00000, 1'b0, 1'b0, 2'b00, 5'd0, 1'b0, 32'h600, 32'd0, 32'd0});
    vecs.push_back('{3'b000, 1'b0, 2'b00, 2'b00, 32'd5, 32'd5, 32'd0, 32'h0, 32'h0, 5'b00011, 1'b0, 1'b0, 2'b00, 5'd0, 1'b1, 32'h0, 32'd10, 32'd5});
    vecs.push_back('{3'b000, 1'b0, 2'b00, 2'b00, 32'd1, 32'd2, 32'd0, 32'h0, 32'h0, 5'b01100, 1'b0, 1'b0, 2'b00, 5'd0, 1'b1, 32'h0, 32'd3, 32'd2});

    // Power-on reset
    rst = 1'b1;
    drive(vecs[17]);
    @(posedge clk); #1;
    chk_m_zero("por");

    @(negedge clk);
    rst = 1'b0;
    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d.PCSrcE", i),    32'(PCSrcE), 32'(vecs[i].e_pcsrc));
      chk($sformatf("v%0d.PCTargetE", i), PCTargetE,   vecs[i].e_tgt);
      @(posedge clk); #1;
      chk($sformatf("v%0d.ALUResultM", i), ALUResultM,      vecs[i].e_alu);
      chk($sformatf("v%0d.WriteDataM", i), WriteDataM,      vecs[i].e_wd);
      chk($sformatf("v%0d.RdM", i),        32'(RdM),        32'(vecs[i].rd));
      chk($sformatf("v%0d.RegWriteM", i),  32'(RegWriteM),  32'(vecs[i].regw));
      chk($sformatf("v%0d.MemWriteM", i),  32'(MemWriteM),  32'(vecs[i].memw));
      chk($sformatf("v%0d.ResultSrcM", i), 32'(ResultSrcM), 32'(vecs[i].rsrc));
      chk($sformatf("v%0d.PCPlus4M", i),   PCPlus4M,        vecs[i].pc + 32'd4);
      @(negedge clk);
    end

    // Mid-stream reset with a live store/write instruction; redirect stays combinational
    drive('{3'b000, 1'b0, 2'b00, 2'b00, 32'd5, 32'd7, 32'd4, 32'h40, 32'h0, 5'b10000, 1'b1, 1'b1, 2'b01, 5'd9, 1'b1, 32'h44, 32'd12, 32'd7});
    rst = 1'b1;
    #1;
    chk("rst.PCSrcE",    32'(PCSrcE), 32'd1);
    chk("rst.PCTargetE", PCTargetE,   32'h44);
    @(posedge clk); #1;
    chk_m_zero("rst");

    // First post-reset instruction forwards the cleared ALUResultM
    @(negedge clk);
    rst = 1'b0;
    drive('{3'b000, 1'b1, 2'b10, 2'b00, 32'hDEAD, 32'd0, 32'd1, 32'h0, 32'h0, 5'b00000, 1'b1, 1'b0, 2'b00, 5'd2, 1'b0, 32'h1, 32'd1, 32'd0});
    @(posedge clk); #1;
    chk("postrst.ALUResultM", ALUResultM, 32'd1);
    chk("postrst.RegWriteM",  32'(RegWriteM), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset; ports are named clk and rst.
REQ-002 SHALL provide these ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- RegWriteE, MemWriteE, JumpE, BeqE, BneE, BltE, BgeE, ALUSrcE  in  1 each  E-stage control from the D/E register
- ResultSrcE  in  2  writeback select
- ALUControlE  in  3  ALU op
- Rd1E, Rd2E, PCE, ExtImmE, PCPlus4E  in  32 each  E-stage operands
- RdE  in  5  destination register
- ForwardAE, ForwardBE  in  2 each  forwarding selects from the hazard unit
- ResultW  in  32  writeback result
- PCSrcE  out  1  redirect fetch (combinational)
- PCTargetE  out  32  redirect address (combinational)
- RegWriteM, MemWriteM  out  1 each  registered controls
- ResultSrcM  out  2  registered writeback select
- ALUResultM, WriteDataM, PCPlus4M  out  32 each  registered data
- RdM  out  5  registered destination

Function
REQ-003 SHALL select operand A as follows: ForwardAE 00 -> Rd1E; 01 -> ResultW; 10 -> ALUResultM (internal feedback); 11 -> Rd1E.
REQ-004 SHALL select forwarded B (WriteDataE) with the same encoding on ForwardBE and Rd2E.
REQ-005 SHALL use SrcB = ExtImmE when ALUSrcE=1, else WriteDataE.
REQ-006 SHALL implement ALUControlE on SrcA/SrcB, 32-bit, wrap-around with no overflow flag:
- 000 add
- 001 sub
- 010 and
- 011 or
- 100 xor
- 101 slt (signed; 1 or 0)
- 110 sltu
- 111 pass SrcB (lui)
REQ-007 SHALL form Zero = (SrcA == WriteDataE) and Lt = signed(SrcA) < signed(WriteDataE), independent of ALUControlE and ALUSrcE.
REQ-008 SHALL compute PCSrcE = JumpE | (BeqE & Zero) | (BneE & ~Zero) | (BltE & Lt) | (BgeE & ~Lt); multiple asserted branch flags are OR-ed.
REQ-009 SHALL compute PCTargetE = PCE + ExtImmE, mod 2^32.
REQ-010 SHALL register on each rising clk: RegWriteE, ResultSrcE, MemWriteE, ALUResult, WriteDataE, RdE and PCPlus4E into the *M outputs (latency 1 cycle, no stall or enable).
REQ-011 SHALL drive PCSrcE and PCTargetE combinationally in the same cycle; neither is registered.
REQ-012 SHALL pass a bubble from the D/E register (all controls 0) as RegWriteM=0 and MemWriteM=0 with no side effects.
REQ-013 SHALL, on back-to-back dependent instructions with ForwardAE=10, use the ALUResultM value present before the current edge.

Reset
REQ-014 SHALL, when rst=1 at a rising edge, clear every *M output to 0; rst has priority over capture.
REQ-015 SHALL leave PCSrcE and PCTargetE combinational and unaffected by rst.
REQ-016 SHALL, when rst is asserted mid-stream, discard the in-flight E instruction; the first post-reset cycle presents ALUResultM=0 for forwarding.

Structure
REQ-017 SHALL place the ALUControl encodings, ResultSrc encodings and Forward select encodings in a shared package used by the decoder, hazard unit and this block.
REQ-018 SHALL be built from one sub-module, alu (32-bit, 3-bit op, combinational), plus the forwarding muxes, the branch logic and the E/M register in this module.

Verification
REQ-019 Rd1E=5, Rd2E=7, ALUControlE=000, ALUSrcE=0, RdE=3, RegWriteE=1 -> after one edge: ALUResultM=12, RdM=3, RegWriteM=1.
REQ-020 Previous ALUResultM=12, ForwardAE=10, Rd1E=0, ExtImmE=4, ALUSrcE=1, add -> next ALUResultM=16.
REQ-021 BltE=1, Rd1E=0xFFFFFFFF, Rd2E=1, PCE=0x100, ExtImmE=0x20 -> PCSrcE=1 and PCTargetE=0x120; same operands with BgeE=1 -> PCSrcE=0.
REQ-022 BneE=1 with ALUSrcE=1, Rd1E=Rd2E=9, ExtImmE=3 -> PCSrcE=0 (the compare ignores the immediate).
REQ-023 rst=1 for one edge while RegWriteE=MemWriteE=1 -> all *M outputs are 0 after that edge.
REQ-024 add 0x7FFFFFFF+1 -> ALUResultM=0x80000000; slt 0x80000000<1 -> 1; sltu -> 0.
